// File: rtl/nes_fb_pkg.sv
// nes_fb_pkg: shared frame-buffer widths, write-entry struct and slot encoding.
package nes_fb_pkg;
    localparam int FB_ADDR_W = 16;
    localparam int FB_WORDS  = 61440;
    localparam int FB_DATA_W = 8;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } fb_wr_t;
    typedef enum logic [1:0] {SLOT_IDLE, SLOT_RD, SLOT_WR, SLOT_FORCE_WR} fb_slot_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO buffering PPU writes until the RAM has a free slot.
// Ports: pix_clk/rst_n (sync, active-low); push/din enqueue; pop dequeues the head;
//        dout is the head entry; count/full/empty report occupancy.
module fb_wr_fifo
    import nes_fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     pix_clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  fb_wr_t                   din,
    output fb_wr_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    fb_wr_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    always_ff @(posedge pix_clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the frame-buffer RAM between VGA reads (priority) and buffered PPU writes.
// Ports: pix_clk/rst_n (sync, active-low); rd_req/rd_addr -> rd_data/rd_valid/rd_miss two cycles later;
//        wr_valid/wr_ready/wr_addr/wr_data PPU write handshake; ram_* registered RAM interface;
//        fifo_level write-buffer occupancy; addr_err sticky out-of-range write flag.
module fb_access_arbiter
    import nes_fb_pkg::*;
#(
    parameter int WR_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 512
) (
    input  logic                             pix_clk,
    input  logic                             rst_n,
    input  logic                             rd_req,
    input  logic [15:0]                      rd_addr,
    output logic [7:0]                       rd_data,
    output logic                             rd_valid,
    output logic                             rd_miss,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [15:0]                      wr_addr,
    input  logic [7:0]                       wr_data,
    output logic [15:0]                      ram_addr,
    output logic                             ram_we,
    output logic [7:0]                       ram_wdata,
    input  logic [7:0]                       ram_rdata,
    output logic [$clog2(WR_FIFO_DEPTH):0]   fifo_level,
    output logic                             addr_err
);
    localparam int SW = $clog2(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
    logic      full, empty, push, pop, rd_v1, rd_m1;
    logic [SW-1:0] starve_cnt;
    fb_wr_t    head;
    fb_slot_e  slot;
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = slot == SLOT_WR || slot == SLOT_FORCE_WR;
    assign rd_data  = ram_rdata;
    always_comb begin
        slot = (starve_cnt == STARVE_MAX && !empty) ? SLOT_FORCE_WR :
               rd_req                               ? SLOT_RD :
               !empty                               ? SLOT_WR : SLOT_IDLE;
    end
    fb_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_fifo (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     ('{addr: wr_addr, data: wr_data}),
        .dout    (head),
        .count   (fifo_level),
        .full    (full),
        .empty   (empty)
    );
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            rd_v1      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_m1      <= 1'b0;
            rd_miss    <= 1'b0;
            starve_cnt <= '0;
            addr_err   <= 1'b0;
        end else begin
            // out-of-range entries still leave the FIFO, they just never reach the RAM
            ram_we     <= pop && head.addr < 16'(FB_WORDS);
            ram_addr   <= slot == SLOT_RD ? rd_addr : pop ? head.addr : ram_addr;
            ram_wdata  <= pop ? head.data : ram_wdata;
            rd_v1      <= slot == SLOT_RD;
            rd_valid   <= rd_v1;
            rd_m1      <= slot == SLOT_FORCE_WR && rd_req;
            rd_miss    <= rd_m1;
            starve_cnt <= (slot == SLOT_FORCE_WR || !full || !rd_req) ? '0 :
                          starve_cnt == STARVE_MAX ? starve_cnt : starve_cnt + 1'b1;
            addr_err   <= addr_err || (push && wr_addr >= 16'(FB_WORDS));
        end
    end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: randomized scoreboard bench with a transaction-level model of the arbiter.
module tb_fb_access_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 512;
    localparam int WORDS = 61440;
    typedef struct {int cyc; logic [15:0] a; logic [7:0] d; logic miss;} exp_t;
    typedef struct {logic [15:0] a; logic [7:0] d;} ent_t;

    logic pix_clk = 0, rst_n = 0, rd_req = 0, wr_valid = 0;
    logic [15:0] rd_addr = 0, wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic [7:0] rd_data, ram_wdata, ram_rdata;
    logic rd_valid, rd_miss, wr_ready, ram_we, addr_err;
    logic [15:0] ram_addr;
    logic [2:0] fifo_level;

    fb_access_arbiter #(.WR_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .pix_clk(pix_clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_miss(rd_miss),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .addr_err(addr_err)
    );

    always #40 pix_clk = ~pix_clk;

    logic [7:0] mem [65536];
    logic [7:0] mmem [65536];
    always @(posedge pix_clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge pix_clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model state
    ent_t mq[$];
    exp_t wexp[$], rexp[$];
    int m_starve = 0;
    logic m_err = 0;

    // monitor
    logic mon_en = 0;
    int we_seen = 0, miss_seen = 0, we_cyc = 0;
    always @(negedge pix_clk) if (mon_en) begin
        exp_t e;
        if (ram_we === 1'b1) begin
            we_seen++;
            we_cyc = cyc;
            if (wexp.size() == 0) chk("ram_we_unexpected", 1, 0);
            else begin
                e = wexp.pop_front();
                chk("wr_cyc", cyc, e.cyc);
                chk("wr_addr", ram_addr, e.a);
                chk("wr_data", ram_wdata, e.d);
            end
        end
        if (rd_valid === 1'b1 || rd_miss === 1'b1) begin
            if (rd_miss === 1'b1) miss_seen++;
            if (rexp.size() == 0) chk("rd_unexpected", {rd_valid, rd_miss}, 0);
            else begin
                e = rexp.pop_front();
                chk("rd_cyc", cyc, e.cyc);
                chk("rd_miss", rd_miss, e.miss);
                chk("rd_valid", rd_valid, !e.miss);
                if (!e.miss) chk("rd_data", rd_data, e.d);
            end
        end
        if (wexp.size() != 0 && wexp[0].cyc < cyc) begin
            chk("wr_missing", 0, wexp[0].cyc);
            void'(wexp.pop_front());
        end
        if (rexp.size() != 0 && rexp[0].cyc < cyc) begin
            chk("rd_missing", 0, rexp[0].cyc);
            void'(rexp.pop_front());
        end
    end

    // drive one cycle; called #1 after a rising edge
    task automatic step(input logic rst, input logic rq, input logic [15:0] ra,
                        input logic wv, input logic [15:0] wa, input logic [7:0] wd);
        int n;
        logic full, empty, frc, wslot;
        ent_t e;
        n = cyc;
        rst_n = rst; rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        chk("fifo_level", fifo_level, mq.size());
        chk("wr_ready", wr_ready, mq.size() < DEPTH);
        chk("addr_err", addr_err, m_err);
        if (!rst) begin
            while (wexp.size() != 0 && wexp[$].cyc > n) void'(wexp.pop_back());
            while (rexp.size() != 0 && rexp[$].cyc > n) void'(rexp.pop_back());
            mq.delete();
            m_starve = 0;
            m_err = 0;
        end else begin
            full  = mq.size() == DEPTH;
            empty = mq.size() == 0;
            frc   = m_starve == LIMIT - 1 && !empty;
            wslot = frc || (!rq && !empty);
            if (rq) rexp.push_back('{cyc: n + 2, a: ra, d: mmem[ra], miss: frc});
            if (wslot) begin
                e = mq.pop_front();
                if (e.a < WORDS) begin
                    wexp.push_back('{cyc: n + 1, a: e.a, d: e.d, miss: 1'b0});
                    mmem[e.a] = e.d;
                end
            end
            if (wv && !full) begin
                mq.push_back('{a: wa, d: wd});
                if (wa >= WORDS) m_err = 1;
            end
            m_starve = frc ? 0 : (full && rq) ? ((m_starve + 1 > LIMIT - 1) ? LIMIT - 1 : m_starve + 1) : 0;
        end
        @(posedge pix_clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int w0, m0, c4;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            mmem[i] = mem[i];
        end
        mem[16'h0123] = 8'h2A;
        mmem[16'h0123] = 8'h2A;
        // T1: reset values
        repeat (3) @(posedge pix_clk);
        #1;
        chk("t1_ram_we", ram_we, 0);
        chk("t1_ram_addr", ram_addr, 0);
        chk("t1_ram_wdata", ram_wdata, 0);
        chk("t1_rd_valid", rd_valid, 0);
        chk("t1_rd_miss", rd_miss, 0);
        chk("t1_addr_err", addr_err, 0);
        chk("t1_fifo_level", fifo_level, 0);
        chk("t1_wr_ready", wr_ready, 1);
        mon_en = 1;
        // T2: read latency
        step(1, 1, 16'h0123, 0, 0, 0);
        chk("t2_ram_addr", ram_addr, 16'h0123);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_data", rd_data, 8'h2A);
        idle(3);
        // T3: writes wait behind a long read burst, then drain in order
        w0 = we_seen;
        for (int i = 0; i < 256; i++)
            step(1, 1, 16'($urandom_range(0, 63)), i < 4, 16'(100 + i), 8'(8'hA0 + i));
        chk("t3_no_we_during_reads", we_seen - w0, 0);
        idle(6);
        chk("t3_we_after_reads", we_seen - w0, 4);
        // T4: fifth offer blocked while full, transfers one cycle after rd_req drops
        for (int i = 0; i < 4; i++) step(1, 1, 16'(i), 1, 16'(200 + i), 8'(8'hB0 + i));
        chk("t4_level_full", fifo_level, 4);
        chk("t4_ready5", wr_ready, 0);
        step(1, 1, 16'd4, 1, 16'd204, 8'hB4);
        step(1, 0, 0, 1, 16'd204, 8'hB4);
        chk("t4_late_accept", wr_ready, 1);
        step(1, 0, 0, 1, 16'd204, 8'hB4);
        idle(8);
        // T5: starvation guard forces exactly one write
        for (int i = 0; i < 4; i++) step(1, 1, 16'(i), 1, 16'(300 + i), 8'(8'hC0 + i));
        w0 = we_seen;
        m0 = miss_seen;
        c4 = cyc;
        for (int i = 0; i < 600; i++) step(1, 1, 16'($urandom_range(0, 63)), 0, 0, 0);
        chk("t5_one_we", we_seen - w0, 1);
        chk("t5_force_cyc", we_cyc, c4 + 512);
        idle(2);
        chk("t5_one_miss", miss_seen - m0, 1);
        idle(6);
        // T6: out-of-range write is accepted, flagged, never written
        w0 = we_seen;
        step(1, 0, 0, 1, 16'hF000, 8'h55);
        idle(4);
        chk("t6_addr_err", addr_err, 1);
        chk("t6_no_we", we_seen - w0, 0);
        idle(4);
        chk("t6_sticky", addr_err, 1);
        // T1b: reset mid-drain discards pending writes
        for (int i = 0; i < 3; i++) step(1, 1, 16'(i), 1, 16'(400 + i), 8'(8'hD0 + i));
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        w0 = we_seen;
        chk("t1b_level", fifo_level, 0);
        chk("t1b_err_clr", addr_err, 0);
        idle(8);
        chk("t1b_no_we", we_seen - w0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] wa;
            wa = ($urandom_range(0, 19) == 0) ? 16'(WORDS + $urandom_range(0, 4000)) : 16'($urandom_range(0, 31));
            step(1, $urandom_range(0, 9) < 7, 16'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, wa, 8'($urandom));
        end
        idle(12);
        chk("wexp_left", wexp.size(), 0);
        chk("rexp_left", rexp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
